// File: rtl/scan_slot_scheduler_pkg.sv
// Shared constants, state encoding and helpers for the scan slot scheduler
// and the display top-levels that instantiate it.
package scan_slot_scheduler_pkg;

    localparam int NUM_SLOTS     = 8;
    localparam int SLOT_W        = 3;
    localparam int DEFAULT_DWELL = 3;
    localparam int DEFAULT_BLANK = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        BLANK = 2'd2
    } state_e;

    function automatic logic [NUM_SLOTS-1:0] slot_onehot(input logic [SLOT_W-1:0] idx);
        logic [NUM_SLOTS-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/scan_slot_scheduler_rr_slot_finder.sv
// Rotate-and-priority search: first requesting slot after ptr, wrapping
// around and ending at ptr itself so a lone requester can be re-granted.
module rr_slot_finder
    import scan_slot_scheduler_pkg::*;
(
    input  logic [NUM_SLOTS-1:0] req_i,
    input  logic [SLOT_W-1:0]    ptr_i,
    output logic                 found_o,
    output logic [SLOT_W-1:0]    idx_o,
    output logic                 wrap_o
);

    logic              hit;
    logic [SLOT_W-1:0] cand;
    logic [SLOT_W-1:0] winner;

    always_comb begin
        hit    = 1'b0;
        cand   = '0;
        winner = '0;
        for (int i = 1; i <= NUM_SLOTS; i++) begin
            cand = ptr_i + SLOT_W'(i);
            if (!hit && req_i[cand]) begin
                hit    = 1'b1;
                winner = cand;
            end
        end
    end

    // A winner at or below the old pointer means the search passed slot 7.
    assign found_o = hit;
    assign idx_o   = winner;
    assign wrap_o  = hit && (winner <= ptr_i);

endmodule

// File: rtl/scan_slot_scheduler.sv
// Round-robin time-sharing of one output driver among 8 slots, with a
// programmable dwell per grant, optional blanking gap and sweep-end pulse.
module scan_slot_scheduler
    import scan_slot_scheduler_pkg::*;
#(
    parameter int BLANK_CYCLES = DEFAULT_BLANK,
    parameter int DWELL_W      = 4
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 enable_i,
    input  logic [NUM_SLOTS-1:0] req_i,
    input  logic [DWELL_W-1:0]   dwell_i,
    output logic [NUM_SLOTS-1:0] grant_o,
    output logic [SLOT_W-1:0]    slot_o,
    output logic                 valid_o,
    output logic                 sweep_done_o
);

    localparam int BLANK_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES + 1) : 1;

    state_e               state_q;
    logic [SLOT_W-1:0]    ptr_q;
    logic [DWELL_W-1:0]   dwell_q;
    logic [BLANK_W-1:0]   blank_q;
    logic [NUM_SLOTS-1:0] grant_q;
    logic                 valid_q;
    logic                 sweep_q;

    logic                 found;
    logic [SLOT_W-1:0]    win_idx;
    logic                 wrap;
    logic                 hold_end;
    logic                 blank_end;
    logic                 decide;

    rr_slot_finder u_finder (
        .req_i   (req_i),
        .ptr_i   (ptr_q),
        .found_o (found),
        .idx_o   (win_idx),
        .wrap_o  (wrap)
    );

    // A grant ends on dwell expiry or when its own request goes away.
    assign hold_end  = (state_q == HOLD) && ((dwell_q == '0) || !req_i[ptr_q]);
    assign blank_end = (state_q == BLANK) && (blank_q == '0);
    assign decide    = found && ((state_q == IDLE) || blank_end ||
                                 (hold_end && (BLANK_CYCLES == 0)));

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            ptr_q   <= SLOT_W'(NUM_SLOTS - 1);
            dwell_q <= '0;
            blank_q <= '0;
            grant_q <= '0;
            valid_q <= 1'b0;
            sweep_q <= 1'b0;
        end else if (!enable_i) begin
            state_q <= IDLE;
            dwell_q <= '0;
            blank_q <= '0;
            grant_q <= '0;
            valid_q <= 1'b0;
            sweep_q <= 1'b0;
        end else if (decide) begin
            state_q <= HOLD;
            ptr_q   <= win_idx;
            dwell_q <= dwell_i;
            blank_q <= '0;
            grant_q <= slot_onehot(win_idx);
            valid_q <= 1'b1;
            sweep_q <= wrap;
        end else begin
            sweep_q <= 1'b0;
            case (state_q)
                HOLD: begin
                    if (hold_end) begin
                        grant_q <= '0;
                        valid_q <= 1'b0;
                        dwell_q <= '0;
                        if (BLANK_CYCLES > 0) begin
                            state_q <= BLANK;
                            blank_q <= BLANK_W'(BLANK_CYCLES - 1);
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        dwell_q <= dwell_q - DWELL_W'(1);
                    end
                end
                // Final blank cycle with nothing requesting falls back to idle.
                BLANK: begin
                    if (blank_end) begin
                        state_q <= IDLE;
                    end else begin
                        blank_q <= blank_q - BLANK_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign grant_o      = grant_q;
    assign slot_o       = ptr_q;
    assign valid_o      = valid_q;
    assign sweep_done_o = sweep_q;

endmodule

// File: tb/tb_scan_slot_scheduler.sv
// Directed, table-driven bench for scan_slot_scheduler: one instance with
// back-to-back grants and one with a single blanking cycle, sharing inputs.
module tb_scan_slot_scheduler;

    logic       clk    = 1'b0;
    logic       reset  = 1'b0;
    logic       enable = 1'b0;
    logic [7:0] req    = 8'h00;
    logic [3:0] dwell  = 4'd0;

    logic [7:0] grant0, grant1;
    logic [2:0] slot0, slot1;
    logic       valid0, valid1;
    logic       sweep0, sweep1;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    scan_slot_scheduler #(.BLANK_CYCLES(0), .DWELL_W(4)) dut0 (
        .clk_i        (clk),
        .reset_i      (reset),
        .enable_i     (enable),
        .req_i        (req),
        .dwell_i      (dwell),
        .grant_o      (grant0),
        .slot_o       (slot0),
        .valid_o      (valid0),
        .sweep_done_o (sweep0)
    );

    scan_slot_scheduler #(.BLANK_CYCLES(1), .DWELL_W(4)) dut1 (
        .clk_i        (clk),
        .reset_i      (reset),
        .enable_i     (enable),
        .req_i        (req),
        .dwell_i      (dwell),
        .grant_o      (grant1),
        .slot_o       (slot1),
        .valid_o      (valid1),
        .sweep_done_o (sweep1)
    );

    typedef struct {
        bit         doReset;
        int         dut;
        bit         en;
        logic [7:0] req;
        logic [3:0] dwell;
        logic [7:0] expGrant;
        logic [2:0] expSlot;
        bit         expValid;
        bit         expSweep;
    } vec_t;

    vec_t vecs[$];

    function automatic void addVec(input bit r, input int d, input bit e,
                                   input logic [7:0] rq, input logic [3:0] dw,
                                   input logic [7:0] g, input logic [2:0] s,
                                   input bit v, input bit sw);
        vec_t x;
        x.doReset  = r;
        x.dut      = d;
        x.en       = e;
        x.req      = rq;
        x.dwell    = dw;
        x.expGrant = g;
        x.expSlot  = s;
        x.expValid = v;
        x.expSweep = sw;
        vecs.push_back(x);
    endfunction

    task automatic applyStimulus(input bit e, input logic [7:0] rq, input logic [3:0] dw);
        enable = e;
        req    = rq;
        dwell  = dw;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int d, input logic [7:0] g,
                               input logic [2:0] s, input bit v, input bit sw);
        logic [7:0] ag;
        logic [2:0] as;
        logic       av;
        logic       asw;
        if (d == 0) begin
            ag = grant0; as = slot0; av = valid0; asw = sweep0;
        end else begin
            ag = grant1; as = slot1; av = valid1; asw = sweep1;
        end
        compared++;
        if (ag !== g || as !== s || av !== v || asw !== sw) begin
            mismatched++;
            $display("[TB] FAIL %s (dut%0d): got grant=%h slot=%0d valid=%b sweep=%b, want grant=%h slot=%0d valid=%b sweep=%b",
                     name, d, ag, as, av, asw, g, s, v, sw);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // All slots requesting, dwell 0, no blanking: one cycle per slot.
        addVec(1, 0, 1, 8'hFF, 4'd0, 8'h01, 3'd0, 1, 1);
        for (int k = 1; k < 8; k++)
            addVec(0, 0, 1, 8'hFF, 4'd0, 8'(1 << k), 3'(k), 1, 0);
        addVec(0, 0, 1, 8'hFF, 4'd0, 8'h01, 3'd0, 1, 1);

        // Slots 2 and 5 with dwell 2 and one blank cycle; dwell changes while held are ignored.
        addVec(1, 1, 1, 8'h24, 4'd2, 8'h04, 3'd2, 1, 1);
        addVec(0, 1, 1, 8'h24, 4'd9, 8'h04, 3'd2, 1, 0);
        addVec(0, 1, 1, 8'h24, 4'd9, 8'h04, 3'd2, 1, 0);
        addVec(0, 1, 1, 8'h24, 4'd9, 8'h00, 3'd2, 0, 0);
        addVec(0, 1, 1, 8'h24, 4'd2, 8'h20, 3'd5, 1, 0);
        addVec(0, 1, 1, 8'h24, 4'd9, 8'h20, 3'd5, 1, 0);
        addVec(0, 1, 1, 8'h24, 4'd9, 8'h20, 3'd5, 1, 0);
        addVec(0, 1, 1, 8'h24, 4'd9, 8'h00, 3'd5, 0, 0);
        addVec(0, 1, 1, 8'h24, 4'd2, 8'h04, 3'd2, 1, 1);

        // Slot 3 loses its request mid-dwell, slot 6 takes over after the blank.
        addVec(1, 1, 1, 8'h08, 4'd7, 8'h08, 3'd3, 1, 1);
        addVec(0, 1, 1, 8'h08, 4'd7, 8'h08, 3'd3, 1, 0);
        addVec(0, 1, 1, 8'h40, 4'd7, 8'h00, 3'd3, 0, 0);
        addVec(0, 1, 1, 8'h40, 4'd7, 8'h40, 3'd6, 1, 0);

        // Lone requester re-granted continuously, sweep pulse on each re-grant.
        addVec(1, 0, 1, 8'h10, 4'd1, 8'h10, 3'd4, 1, 1);
        addVec(0, 0, 1, 8'h10, 4'd1, 8'h10, 3'd4, 1, 0);
        addVec(0, 0, 1, 8'h10, 4'd1, 8'h10, 3'd4, 1, 1);
        addVec(0, 0, 1, 8'h10, 4'd1, 8'h10, 3'd4, 1, 0);
        addVec(0, 0, 1, 8'h10, 4'd1, 8'h10, 3'd4, 1, 1);

        // Enable dropped mid-hold on slot 5; pointer kept, resumes at slot 6.
        addVec(1, 0, 1, 8'h20, 4'd5, 8'h20, 3'd5, 1, 1);
        addVec(0, 0, 1, 8'h20, 4'd5, 8'h20, 3'd5, 1, 0);
        addVec(0, 0, 0, 8'hFF, 4'd5, 8'h00, 3'd5, 0, 0);
        addVec(0, 0, 0, 8'hFF, 4'd5, 8'h00, 3'd5, 0, 0);
        addVec(0, 0, 0, 8'hFF, 4'd5, 8'h00, 3'd5, 0, 0);
        addVec(0, 0, 1, 8'hFF, 4'd0, 8'h40, 3'd6, 1, 0);
        addVec(0, 0, 1, 8'hFF, 4'd0, 8'h80, 3'd7, 1, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].doReset) begin
                applyStimulus(vecs[i].en, vecs[i].req, vecs[i].dwell);
                reset = 1'b1;
                tick();
                checkOutput($sformatf("reset before vec%0d", i), 0, 8'h00, 3'd7, 0, 0);
                checkOutput($sformatf("reset before vec%0d", i), 1, 8'h00, 3'd7, 0, 0);
                reset = 1'b0;
            end
            applyStimulus(vecs[i].en, vecs[i].req, vecs[i].dwell);
            tick();
            checkOutput($sformatf("vec%0d", i), vecs[i].dut, vecs[i].expGrant,
                        vecs[i].expSlot, vecs[i].expValid, vecs[i].expSweep);
        end

        // Reset asserted between clock edges while holding slot 0.
        applyStimulus(1, 8'hFF, 4'd7);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        checkOutput("async setup grant", 1, 8'h01, 3'd0, 1, 1);
        tick();
        checkOutput("async setup hold", 1, 8'h01, 3'd0, 1, 0);
        #3;
        reset = 1'b1;
        #1;
        checkOutput("async reset mid-cycle", 0, 8'h00, 3'd7, 0, 0);
        checkOutput("async reset mid-cycle", 1, 8'h00, 3'd7, 0, 0);
        reset = 1'b0;
        applyStimulus(0, 8'h00, 4'd0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/scan_slot_scheduler.md
Name: scan_slot_scheduler

Overview:
- Round-robin scheduler that time-shares one output resource (display digit or column driver) among 8 requesting slots.
- Holds each granted slot for a programmable dwell time.
- Inserts optional blanking between grants to prevent ghosting.
- Flags the end of each full sweep, with the same role as a 3-bit slot counter's loop-end flag. Sits between per-slot request logic and the shared decoder/driver.

Parameters:
- BLANK_CYCLES, 1, cycles with no grant between consecutive grants (0 = back-to-back grants).
- DWELL_W, 4, width of the dwell input and internal dwell down-counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  scheduler runs when high; low forces a synchronous stop.
- req  in  8  per-slot request, bit i = slot i.
- dwell  in  DWELL_W  hold length; slot is held dwell+1 cycles.
- grant  out  8  one-hot grant, all-zero when idle or blanking.
- slot  out  3  index of the current or last granted slot.
- valid  out  1  high when grant is non-zero.
- sweep_done  out  1  1-cycle pulse when a grant decision wraps the pointer.

Behaviour:
- Reset (async) values: grant=0, valid=0, sweep_done=0, slot=7, internal pointer=7, state=IDLE, dwell/blank counters=0.
- All outputs are registered.
- States:
  - IDLE: no grant.
  - HOLD: grant asserted.
  - BLANK: grant=0, blank counter running.
- Arbitration (a "decision"):
  - Search req starting at pointer+1, wrapping 7->0, up to and including the pointer itself.
  - The first set bit wins.
  - slot and pointer take the winner index; grant becomes one-hot of the winner.
  - The dwell counter loads the dwell value sampled in that cycle; state becomes HOLD.
  - With a single requester, that slot is re-granted after each dwell/blank.
- IDLE: each cycle with enable=1 and req!=0 makes a decision; grant is visible on the next edge (latency 1 cycle). req=0 stays in IDLE.
- HOLD:
  - The dwell counter decrements each cycle.
  - When the counter equals 0, or the granted req bit drops, the grant ends on the next edge.
  - If BLANK_CYCLES>0, go to BLANK; otherwise a decision is made in the same cycle (back-to-back grant, no gap). With no request pending in that case, go to IDLE.
  - Changes to dwell during HOLD are ignored.
- BLANK: grant=0 for exactly BLANK_CYCLES cycles. On the last one, make a decision if req!=0, else go to IDLE.
- sweep_done:
  - Pulses high for exactly the cycle in which the new grant first appears, when the new winner index <= the previous pointer (wrap past slot 7).
  - The first grant after reset from pointer 7 counts as a wrap, so it pulses.
- Requests appearing or vanishing on non-granted slots only affect the next decision; there is no preemption.
- enable=0:
  - On the next edge: grant=0, valid=0, state=IDLE, counters cleared, sweep_done=0.
  - pointer and slot are retained; re-enable resumes round-robin after the retained pointer.
- Reset mid-HOLD/BLANK: immediate return to reset values, independent of clk.
- dwell=0: each grant lasts exactly 1 cycle.

Decomposition:
- Shared package holds:
  - NUM_SLOTS=8 and SLOT_W=3.
  - State encoding IDLE/HOLD/BLANK.
  - Default dwell and blank constants used by display top-levels.
- One sub-module, rr_slot_finder: combinational rotate-and-priority search.
  - Inputs: req[7:0], ptr[2:0].
  - Outputs: found, idx[2:0], wrap.
- FSM, counters and output registers live in scan_slot_scheduler.

Test Plan:
- Reset with req=8'hFF, dwell=0, BLANK_CYCLES=0, enable=1 -> after release, slot sequence 0,1,...,7,0 with one cycle each; sweep_done high on the cycles granting slot 0.
- req=8'b0010_0100, dwell=2, BLANK_CYCLES=1 -> grant slot 2 for 3 cycles, 1 zero cycle, slot 5 for 3 cycles, 1 zero cycle, slot 2 with sweep_done=1.
- Holding slot 3 with dwell=7: drop req[3] after 2 cycles, req[6]=1 -> grant=0 on the next edge (BLANK), then slot 6 granted; no sweep_done.
- Only req[4]=1, dwell=1, BLANK_CYCLES=0 -> grant stays 8'h10 continuously, sweep_done pulses at each re-grant (every 2 cycles).
- Mid-HOLD on slot 5, drop enable for 3 cycles with req=8'hFF, then raise it -> grant=0 the cycle after enable falls; first grant after re-enable is slot 6.
- Assert reset asynchronously between clock edges during HOLD -> grant=0, slot=7, valid=0 immediately, before the next clk edge.
